fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the write port of one FIFO between N_REQ independent producers using round-robin arbitration.
- Captures one requester word into a holding register and drives the FIFO write signals (wr_en, data_in).
- Checks the FIFO's wr_ack/overflow response and retries a rejected write up to MAX_RETRY times before dropping it.
- Sits directly in front of the FIFO write port; the FIFO read side is untouched.

Parameters:
- N_REQ, 4: number of requesters, 2..8, need not be a power of 2.
- FIFO_WIDTH, 16: data width, matches the FIFO.
- MAX_RETRY, 3: extra write attempts after the first rejected one.
- CNT_W, 16: width of the statistics counters.
- ID_W, $clog2(N_REQ): requester index width (derived, not user-set).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  N_REQ  per-requester valid.
- req_data  in  N_REQ*FIFO_WIDTH  requester i occupies [i*FIFO_WIDTH +: FIFO_WIDTH].
- req_ready  out  N_REQ  one-hot accept strobe.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_data_in  out  FIFO_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_ack  in  1  FIFO write acknowledge, one cycle after wr_en.
- fifo_overflow  in  1  FIFO overflow flag, one cycle after wr_en.
- clr_stats  in  1  synchronous clear of both counters.
- busy  out  1  high whenever state is not IDLE.
- drop_pulse  out  1  one-cycle pulse when a word is dropped.
- drop_id  out  ID_W  requester index of the last dropped word.
- retry_cnt  out  CNT_W  saturating count of retries.
- drop_cnt  out  CNT_W  saturating count of drops.

Behaviour:
- Reset (asynchronous): state=IDLE, rr_ptr=0, hold_data=0, hold_id=0, attempt=0, retry_cnt=0, drop_cnt=0, drop_pulse=0, drop_id=0. Resulting outputs: req_ready=0, fifo_wr_en=0, fifo_data_in=0, busy=0.
- Reset mid-operation: any held word is discarded silently and counters do not increment.
- FSM has three states: IDLE, WRITE, CHECK.
- IDLE:
  - If any req_valid is high, winner = first index i, searching rr_ptr, rr_ptr+1, ... with modulo-N_REQ wrap, such that req_valid[i]=1.
  - req_ready[winner]=1 combinationally in the same cycle; all other bits are 0. Handshake completes in that cycle.
  - At the clock edge: hold_data<=req_data[winner], hold_id<=winner, attempt<=0, rr_ptr<=(winner==N_REQ-1)?0:winner+1, go to WRITE.
  - With no valid requester: stay in IDLE, rr_ptr unchanged.
- req_ready is 0 in every state other than IDLE.
- WRITE:
  - fifo_data_in = hold_data.
  - fifo_wr_en = !fifo_full, combinational.
  - If fifo_full, stay in WRITE with no write issued; wait indefinitely.
  - Otherwise go to CHECK.
- CHECK, sampling the FIFO response to the previous cycle's write:
  - fifo_wr_ack=1: word retired, go to IDLE.
  - Otherwise (overflow, or no ack), with attempt<MAX_RETRY: attempt++, retry_cnt++, go to WRITE.
  - Otherwise: drop_pulse=1 for the next cycle, drop_id<=hold_id, drop_cnt++, go to IDLE.
  - fifo_wr_ack and fifo_overflow both high: ack wins.
- Latency and throughput:
  - Accept at edge 0, fifo_wr_en high in cycle 1, response sampled in cycle 2.
  - Back in IDLE in cycle 3; the earliest next accept is cycle 3.
  - Peak throughput is 1 word per 3 cycles.
- fifo_data_in holds hold_data in all states except reset, so data is stable across retries.
- Counters:
  - Saturate at all-ones.
  - clr_stats zeroes them at the next edge and overrides an increment in the same cycle.
  - clr_stats does not affect the FSM or the held word.
- Fairness: a requester holding req_valid continuously is granted within N_REQ grants.

Decomposition:
- Package fifo_arb_pkg holds:
  - state enum arb_state_t {IDLE, WRITE, CHECK}.
  - Counter saturation helper function.
- Sub-module rr_arbiter:
  - Parameter N_REQ.
  - Inputs req and ptr; output one-hot grant plus encoded index.
  - Purely combinational.
- rr_ptr and all registers live in fifo_wr_arbiter.

Test Plan:
- Single requester: req_valid=4'b0001, req_data[15:0]=16'hA5A5, FIFO acks. Expected: req_ready[0] high 1 cycle, fifo_wr_en high 1 cycle later with data 16'hA5A5, busy back to 0 after cycle 3, retry_cnt=0.
- Fairness: all four requesters valid continuously for 12 grants. Expected: grant order 0,1,2,3,0,1,2,3,0,1,2,3, every fifo_wr_en 3 cycles apart.
- Full stall: fifo_full held 1 for 5 cycles after accept. Expected: fifo_wr_en stays 0 for those 5 cycles, asserts in the cycle full drops, no retry counted.
- Retry then drop: FIFO never acks (fifo_overflow=1). Expected: 4 wr_en pulses total, retry_cnt=3, drop_pulse once, drop_id = requester index, drop_cnt=1.
- Retry success: FIFO rejects the first write, acks the second. Expected: retry_cnt=1, drop_cnt=0, same data on both wr_en pulses.
- Reset mid-operation: assert rst in CHECK. Expected: outputs zero immediately without waiting for clk, rr_ptr=0. After release, requester 0 wins first despite the previous pointer.

Source files
------------

// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin selector.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        CHECK = 2'd2
    } arb_state_t;

    // Increment v, holding at the all-ones value of a w-bit counter.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int unsigned w
    );
        logic [31:0] top;
        top = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= top) ? top : v + 32'd1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-port signals shared by the arbiter.
// slave = arbiter side, master = producers plus FIFO side.
interface fifo_wr_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 16
);
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*FIFO_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic                        fifo_wr_en;
    logic [FIFO_WIDTH-1:0]       fifo_data_in;
    logic                        fifo_full;
    logic                        fifo_wr_ack;
    logic                        fifo_overflow;

    modport master (
        output req_valid, req_data,
        output fifo_full, fifo_wr_ack, fifo_overflow,
        input  req_ready, fifo_wr_en, fifo_data_in
    );

    modport slave (
        input  req_valid, req_data,
        input  fifo_full, fifo_wr_ack, fifo_overflow,
        output req_ready, fifo_wr_en, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_arbiter.sv
// Combinational round-robin selector: first set req bit at or after ptr.
// Produces a one-hot grant and its encoded index.
module rr_arbiter #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  idx,
    output logic             any
);

    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            j = (int'(ptr) + k) % N_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin sharing of one FIFO write port between N_REQ producers,
// with bounded retry of rejected writes and saturating statistics.
module fifo_wr_arbiter #(
    parameter  int N_REQ      = 4,
    parameter  int FIFO_WIDTH = 16,
    parameter  int MAX_RETRY  = 3,
    parameter  int CNT_W      = 16,
    localparam int ID_W       = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    fifo_wr_arbiter_if.slave       bus,
    input  logic                   clr_stats,
    output logic                   busy,
    output logic                   drop_pulse,
    output logic [ID_W-1:0]        drop_id,
    output logic [CNT_W-1:0]       retry_cnt,
    output logic [CNT_W-1:0]       drop_cnt
);
    import fifo_arb_pkg::*;

    localparam int ATT_W = $clog2(MAX_RETRY + 2);

    arb_state_t            state_q, state_d;
    logic [ID_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [FIFO_WIDTH-1:0] hold_data_q, hold_data_d;
    logic [ID_W-1:0]       hold_id_q, hold_id_d;
    logic [ATT_W-1:0]      attempt_q, attempt_d;
    logic [CNT_W-1:0]      retry_cnt_q, retry_cnt_d;
    logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
    logic                  drop_pulse_q, drop_pulse_d;
    logic [ID_W-1:0]       drop_id_q, drop_id_d;

    logic [N_REQ-1:0]      grant;
    logic [ID_W-1:0]       win_idx;
    logic                  win_any;
    logic                  retry_inc;
    logic                  drop_inc;
    logic                  nack;
    logic [FIFO_WIDTH-1:0] req_word [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_word
        assign req_word[g] = bus.req_data[g*FIFO_WIDTH +: FIFO_WIDTH];
    end

    rr_arbiter #(.N_REQ(N_REQ)) u_rr (
        .req   (bus.req_valid),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // An overflow or a missing ack both count as a rejected write.
    assign nack = bus.fifo_overflow | ~bus.fifo_wr_ack;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            hold_data_q  <= '0;
            hold_id_q    <= '0;
            attempt_q    <= '0;
            retry_cnt_q  <= '0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            drop_id_q    <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            hold_data_q  <= hold_data_d;
            hold_id_q    <= hold_id_d;
            attempt_q    <= attempt_d;
            retry_cnt_q  <= retry_cnt_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop_pulse_d;
            drop_id_q    <= drop_id_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        hold_data_d  = hold_data_q;
        hold_id_d    = hold_id_q;
        attempt_d    = attempt_q;
        drop_pulse_d = 1'b0;
        drop_id_d    = drop_id_q;
        retry_inc    = 1'b0;
        drop_inc     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (win_any) begin
                    hold_data_d = req_word[win_idx];
                    hold_id_d   = win_idx;
                    attempt_d   = '0;
                    rr_ptr_d    = (win_idx == ID_W'(N_REQ - 1)) ?
                                  '0 : win_idx + 1'b1;
                    state_d     = WRITE;
                end
            end
            WRITE: begin
                if (!bus.fifo_full) state_d = CHECK;
            end
            CHECK: begin
                if (bus.fifo_wr_ack) begin
                    state_d = IDLE;
                end else if (nack && attempt_q < ATT_W'(MAX_RETRY)) begin
                    attempt_d = attempt_q + 1'b1;
                    retry_inc = 1'b1;
                    state_d   = WRITE;
                end else begin
                    drop_pulse_d = 1'b1;
                    drop_id_d    = hold_id_q;
                    drop_inc     = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        retry_cnt_d = retry_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        if (clr_stats) begin
            retry_cnt_d = '0;
            drop_cnt_d  = '0;
        end else begin
            if (retry_inc)
                retry_cnt_d = CNT_W'(sat_inc(32'(retry_cnt_q), CNT_W));
            if (drop_inc)
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), CNT_W));
        end
    end

    // Grant is gated by rst so the strobe drops the instant reset asserts.
    always_comb begin
        bus.req_ready  = '0;
        bus.fifo_wr_en = 1'b0;
        busy           = (state_q != IDLE);
        if (state_q == IDLE && !rst) bus.req_ready = grant;
        if (state_q == WRITE) bus.fifo_wr_en = !bus.fifo_full;
    end

    assign bus.fifo_data_in = hold_data_q;
    assign drop_pulse       = drop_pulse_q;
    assign drop_id          = drop_id_q;
    assign retry_cnt        = retry_cnt_q;
    assign drop_cnt         = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed and randomized checks of fifo_wr_arbiter against a
// round-robin / retry reference model held in the bench.
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MR = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          clr_stats;
    logic          busy;
    logic          drop_pulse;
    logic [1:0]    drop_id;
    logic [CW-1:0] retry_cnt;
    logic [CW-1:0] drop_cnt;

    fifo_wr_arbiter_if #(.N_REQ(N), .FIFO_WIDTH(W)) bus ();

    fifo_wr_arbiter #(
        .N_REQ(N), .FIFO_WIDTH(W), .MAX_RETRY(MR), .CNT_W(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .clr_stats  (clr_stats),
        .busy       (busy),
        .drop_pulse (drop_pulse),
        .drop_id    (drop_id),
        .retry_cnt  (retry_cnt),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int pulses = 0;
    int last_wr = -1;

    int m_ptr   = 0;
    int m_retry = 0;
    int m_drop  = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.fifo_wr_en) pulses <= pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    function automatic int model_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++)
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    // One word end to end; entered at IDLE with req_valid already driven.
    task automatic run_word(input int n_full, input int n_rej,
                            input bit clr_last, input bit chk_gap,
                            output int w);
        int a, ns, p0;
        logic [W-1:0] d;
        bit ack, last, dropped;
        w = model_winner(bus.req_valid);
        d = bus.req_data[w*W +: W];
        p0 = pulses;
        dropped = 1'b0;
        #1;
        chk("idle_busy", busy, 0);
        chk("grant", bus.req_ready, 32'(1 << w));
        chk("idle_wren", bus.fifo_wr_en, 0);
        @(posedge clk); #1;
        m_ptr = (w + 1) % N;
        a = 0;
        last = 1'b0;
        while (!last) begin
            ns = (a == 0) ? n_full : 0;
            for (int s = 0; s < ns; s++) begin
                bus.fifo_full = 1'b1;
                #1;
                chk("stall_wren", bus.fifo_wr_en, 0);
                chk("stall_ready", bus.req_ready, 0);
                chk("stall_busy", busy, 1);
                @(posedge clk); #1;
            end
            bus.fifo_full = 1'b0;
            #1;
            chk("wr_en", bus.fifo_wr_en, 1);
            chk("wr_data", bus.fifo_data_in, d);
            chk("write_ready", bus.req_ready, 0);
            if (chk_gap && last_wr >= 0) chk("wr_gap", cyc - last_wr, 3);
            last_wr = cyc;
            @(posedge clk); #1;
            ack = (a >= n_rej);
            last = ack || (a == MR);
            bus.fifo_wr_ack   = ack;
            bus.fifo_overflow = !ack;
            clr_stats = clr_last && last;
            #1;
            chk("check_wren", bus.fifo_wr_en, 0);
            chk("check_busy", busy, 1);
            @(posedge clk); #1;
            bus.fifo_wr_ack   = 1'b0;
            bus.fifo_overflow = 1'b0;
            clr_stats = 1'b0;
            if (!ack && a < MR) m_retry = sat(m_retry);
            if (!ack && a == MR) begin
                m_drop = sat(m_drop);
                dropped = 1'b1;
            end
            if (clr_last && last) begin
                m_retry = 0;
                m_drop  = 0;
            end
            if (!last) a++;
        end
        #1;
        chk("end_busy", busy, 0);
        chk("drop_pulse", drop_pulse, 32'(dropped));
        if (dropped) chk("drop_id", drop_id, w);
        chk("wr_pulses", pulses - p0, a + 1);
        chk("retry_cnt", retry_cnt, m_retry);
        chk("drop_cnt", drop_cnt, m_drop);
    endtask

    task automatic idle_cycle();
        bus.req_valid = '0;
        #1;
        chk("noreq_ready", bus.req_ready, 0);
        chk("noreq_busy", busy, 0);
        @(posedge clk); #1;
        chk("noreq_stay", busy, 0);
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++)
            bus.req_data[i*W +: W] = W'($urandom);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        clr_stats = 1'b0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.fifo_full = 1'b0;
        bus.fifo_wr_ack = 1'b0;
        bus.fifo_overflow = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_wren", bus.fifo_wr_en, 0);
        chk("rst_data", bus.fifo_data_in, 0);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_retry", retry_cnt, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_pulse", drop_pulse, 0);
        chk("rst_dropid", drop_id, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Fairness: all requesters valid, strict 0..3 rotation, 3-cycle gaps.
        bus.req_valid = 4'hF;
        last_wr = -1;
        for (int i = 0; i < 12; i++) begin
            rand_data();
            run_word(0, 0, 1'b0, 1'b1, w);
            chk("rr_order", w, i % N);
        end

        // Single requester.
        bus.req_valid = 4'b0001;
        bus.req_data = '0;
        bus.req_data[15:0] = 16'hA5A5;
        run_word(0, 0, 1'b0, 1'b0, w);
        idle_cycle();

        // Full stall for five cycles.
        bus.req_valid = 4'b0010;
        rand_data();
        run_word(5, 0, 1'b0, 1'b0, w);

        // Never acked: three retries then drop.
        bus.req_valid = 4'b1000;
        rand_data();
        run_word(0, 4, 1'b0, 1'b0, w);
        chk("drop_req3", drop_id, 3);

        // Rejected once then acked.
        bus.req_valid = 4'b0100;
        rand_data();
        run_word(0, 1, 1'b0, 1'b0, w);

        // Clear in idle.
        bus.req_valid = '0;
        clr_stats = 1'b1;
        @(posedge clk); #1;
        clr_stats = 1'b0;
        m_retry = 0;
        m_drop = 0;
        chk("clr_retry", retry_cnt, 0);
        chk("clr_drop", drop_cnt, 0);

        // Clear coinciding with a drop wins over the increment.
        bus.req_valid = 4'b0001;
        rand_data();
        run_word(0, 4, 1'b1, 1'b0, w);

        // Counter saturation.
        for (int i = 0; i < 6; i++) begin
            bus.req_valid = 4'(1 << (i % N));
            rand_data();
            run_word(0, 4, 1'b0, 1'b0, w);
        end
        chk("sat_retry", retry_cnt, 15);

        // Randomized traffic.
        for (int i = 0; i < 40; i++) begin
            logic [N-1:0] v;
            v = N'($urandom);
            rand_data();
            if (v == '0) idle_cycle();
            else begin
                bus.req_valid = v;
                run_word(int'($urandom_range(0, 2)), int'($urandom_range(0, 4)),
                         ($urandom_range(0, 7) == 0), 1'b0, w);
            end
        end

        // Reset while in CHECK.
        idle_cycle();
        bus.req_valid = 4'b0100;
        rand_data();
        #1;
        chk("pre_rst_grant", bus.req_ready, 4'b0100);
        @(posedge clk); #1;
        bus.req_valid = '0;
        #1;
        chk("pre_rst_wren", bus.fifo_wr_en, 1);
        @(posedge clk); #1;
        bus.fifo_overflow = 1'b1;
        bus.req_valid = 4'hF;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_wren", bus.fifo_wr_en, 0);
        chk("mid_rst_data", bus.fifo_data_in, 0);
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_retry", retry_cnt, 0);
        chk("mid_rst_drop", drop_cnt, 0);
        bus.fifo_overflow = 1'b0;
        bus.req_valid = '0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m_ptr = 0;
        m_retry = 0;
        m_drop = 0;
        chk("post_rst_busy", busy, 0);
        bus.req_valid = 4'hF;
        rand_data();
        run_word(0, 0, 1'b0, 1'b0, w);
        chk("post_rst_first", w, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
